// File: rtl/aes_encrypt.sv
// ---------------------------------------------------------------------------
// aes_encrypt -- iterative AES-128 encryptor, one round per clock.
//
// A START in IDLE or DONE captures key and plaintext, applies the initial
// AddRoundKey, then runs ten rounds with the round key expanded on the fly
// (no stored schedule). The ciphertext uses the same byte order as the
// plaintext, so it can feed the decryption core directly.
//
// Ports:
//   CLK          system clock, all state updates on the rising edge
//   RESET        synchronous, active-high reset
//   AES_START    start request, honoured only in IDLE or DONE
//   AES_KEY      128-bit cipher key, bits [127:120] = key byte 0
//   AES_MSG_PT   128-bit plaintext, bits [127:120] = state byte 0
//                (FIPS-197 column-major: byte 4*c+r is row r, column c)
//   AES_MSG_ENC  128-bit ciphertext, same byte order, held until next result
//   AES_DONE     ciphertext valid
//   AES_BUSY     encryption in progress
// ---------------------------------------------------------------------------

// Shared forward S-box: byte substitution table from FIPS-197.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a)+7.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module aes_encrypt #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         AES_START,
   input  logic [127:0] AES_KEY,
   input  logic [127:0] AES_MSG_PT,
   output logic [127:0] AES_MSG_ENC,
   output logic         AES_DONE,
   output logic         AES_BUSY
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [3:0]   round_q;
   logic [127:0] state_q;
   logic [127:0] rk_q;

   logic         start_acc;
   logic         last_round;
   logic [127:0] sb_out, sr_out, mc_out, round_out;
   logic [31:0]  rot_word, sub_word, key_tmp;
   logic [127:0] next_key;

   // ------------------------------------------------------------------------
   // GF(2^8) helpers and round constants
   // ------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign start_acc  = AES_START && ((fsm_q == IDLE) || (fsm_q == DONE));
   assign last_round = (round_q == 4'(NUM_ROUNDS));

   // ------------------------------------------------------------------------
   // Round function: SubBytes -> ShiftRows -> MixColumns (skipped last round)
   // ------------------------------------------------------------------------
   genvar gi, gc, gr;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_state_sbox
         aes_sbox u_sbox (
            .a (state_q[127-8*gi -: 8]),
            .y (sb_out[127-8*gi -: 8])
         );
      end

      // Row r of column c takes the byte from column (c+r) mod 4.
      for (gc = 0; gc < 4; gc++) begin : g_shift_col
         for (gr = 0; gr < 4; gr++) begin : g_shift_row
            assign sr_out[127-8*(4*gc+gr) -: 8] =
               sb_out[127-8*(4*((gc+gr)%4)+gr) -: 8];
         end
         assign mc_out[127-32*gc -: 32] = mix_col(sr_out[127-32*gc -: 32]);
      end

      // Key expansion: SubWord(RotWord(w3)) on the last word of the current key.
      for (gi = 0; gi < 4; gi++) begin : g_key_sbox
         aes_sbox u_sbox (
            .a (rot_word[31-8*gi -: 8]),
            .y (sub_word[31-8*gi -: 8])
         );
      end
   endgenerate

   assign rot_word = {rk_q[23:0], rk_q[31:24]};
   assign key_tmp  = sub_word ^ {rcon(round_q), 24'h000000};

   // Each new word is the XOR of the word above it and the previous new word.
   assign next_key[127:96] = rk_q[127:96] ^ key_tmp;
   assign next_key[95:64]  = rk_q[95:64]  ^ next_key[127:96];
   assign next_key[63:32]  = rk_q[63:32]  ^ next_key[95:64];
   assign next_key[31:0]   = rk_q[31:0]   ^ next_key[63:32];

   assign round_out = (last_round ? sr_out : mc_out) ^ next_key;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) fsm_q <= IDLE;
      else       fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (AES_START) fsm_d = ROUND;
         ROUND:   if (last_round) fsm_d = DONE;
         DONE:    if (AES_START) fsm_d = ROUND;
         default: fsm_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         round_q     <= 4'd1;
         state_q     <= '0;
         rk_q        <= '0;
         AES_MSG_ENC <= '0;
         AES_DONE    <= 1'b0;
         AES_BUSY    <= 1'b0;
      end else if (start_acc) begin
         state_q  <= AES_MSG_PT ^ AES_KEY;
         rk_q     <= AES_KEY;
         round_q  <= 4'd1;
         AES_DONE <= 1'b0;
         AES_BUSY <= 1'b1;
      end else if (fsm_q == ROUND) begin
         state_q <= round_out;
         rk_q    <= next_key;
         if (last_round) begin
            AES_MSG_ENC <= round_out;
            AES_DONE    <= 1'b1;
            AES_BUSY    <= 1'b0;
         end else begin
            round_q <= round_q + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_aes_encrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt -- self-checking bench for aes_encrypt.
//
// Known-answer table (FIPS-197 C.1, B and a loopback vector), randomized
// operations against a byte-level AES model built from GF(2^8) arithmetic,
// and hand-written sequences for start-while-busy, back-to-back operation,
// mid-operation reset and reset/start collision.
// ---------------------------------------------------------------------------
module tb_aes_encrypt;

   logic         CLK;
   logic         RESET;
   logic         AES_START;
   logic [127:0] AES_KEY;
   logic [127:0] AES_MSG_PT;
   logic [127:0] AES_MSG_ENC;
   logic         AES_DONE;
   logic         AES_BUSY;

   aes_encrypt dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .AES_START   (AES_START),
      .AES_KEY     (AES_KEY),
      .AES_MSG_PT  (AES_MSG_PT),
      .AES_MSG_ENC (AES_MSG_ENC),
      .AES_DONE    (AES_DONE),
      .AES_BUSY    (AES_BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t tbl [3];

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      return (x << k) | (x >> (8 - k));
   endfunction

   // S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sb[a]  = s;
         isb[s] = 8'(a);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   // FIPS-197 KeyExpansion over 44 words; returns round key n.
   function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
      logic [31:0] w [44];
      logic [7:0]  rc;
      logic [31:0] t;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
   endfunction

   function automatic logic [127:0] model_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] k, res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
               for (int w = 0; w < 4; w++)
                  s[4*c+w] = gmul(8'h02, a[w]) ^ gmul(8'h03, a[(w+1)%4]) ^ a[(w+2)%4] ^ a[(w+3)%4];
            end
         end
         k = round_key(key, r);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Inverse cipher, standing in for the decryption core in loopback checks.
   function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] k, res;
      k = round_key(key, 10);
      for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
      for (int r = 10; r >= 1; r--) begin
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[4*((c+w)%4)+w] = s[4*c+w];
         for (int i = 0; i < 16; i++) s[i] = isb[t[i]];
         k = round_key(key, r - 1);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
         if (r > 1) begin
            for (int c = 0; c < 4; c++) begin
               for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
               for (int w = 0; w < 4; w++)
                  s[4*c+w] = gmul(8'h0e, a[w]) ^ gmul(8'h0b, a[(w+1)%4]) ^
                             gmul(8'h0d, a[(w+2)%4]) ^ gmul(8'h09, a[(w+3)%4]);
            end
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- bench helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One-cycle START, then wait (bounded) for DONE; lat counts edges after START.
   task automatic run_op(input logic [127:0] key, input logic [127:0] pt,
                         output logic [127:0] ct, output int lat);
      AES_KEY    = key;
      AES_MSG_PT = pt;
      AES_START  = 1'b1;
      tick();
      AES_START  = 1'b0;
      lat = 0;
      while (!AES_DONE && lat < 30) begin
         tick();
         lat++;
      end
      ct = AES_MSG_ENC;
   endtask

   logic [127:0] ct, rk, rpt;
   int           lat;

   initial begin
      tbl[0] = '{key: KEY_C1, pt: PT_C1, ct: CT_C1};
      tbl[1] = '{key: KEY_C1, pt: 128'hece298dcece298dcece298dcece298dc,
                 ct: 128'hdaec3055df058e1c39e814ea76f6747e};
      tbl[2] = '{key: KEY_B, pt: PT_B, ct: CT_B};

      build_sbox();

      RESET      = 1'b1;
      AES_START  = 1'b0;
      AES_KEY    = '0;
      AES_MSG_PT = '0;
      tick();
      tick();
      check("reset_done", 128'(AES_DONE), 128'd0);
      check("reset_busy", 128'(AES_BUSY), 128'd0);
      check("reset_enc", AES_MSG_ENC, 128'd0);
      RESET = 1'b0;
      tick();

      // Known-answer table, each also checked against the model and decrypted back.
      for (int i = 0; i < 3; i++) begin
         run_op(tbl[i].key, tbl[i].pt, ct, lat);
         check($sformatf("kat%0d_ct", i), ct, tbl[i].ct);
         check($sformatf("kat%0d_model", i), model_enc(tbl[i].key, tbl[i].pt), tbl[i].ct);
         check($sformatf("kat%0d_latency", i), 128'(lat), 128'd10);
         check($sformatf("kat%0d_loopback", i), model_dec(tbl[i].key, ct), tbl[i].pt);
      end

      // Randomized operations against the model.
      for (int i = 0; i < 8; i++) begin
         rk  = {$urandom, $urandom, $urandom, $urandom};
         rpt = {$urandom, $urandom, $urandom, $urandom};
         run_op(rk, rpt, ct, lat);
         check($sformatf("rand%0d_ct", i), ct, model_enc(rk, rpt));
         check($sformatf("rand%0d_latency", i), 128'(lat), 128'd10);
      end

      // App. B with the round-1 key observed one edge after the start edge.
      AES_KEY    = KEY_B;
      AES_MSG_PT = PT_B;
      AES_START  = 1'b1;
      tick();
      AES_START  = 1'b0;
      tick();
      check("b_round1_key", dut.rk_q, 128'ha0fafe1788542cb123a339392a6c7605);
      lat = 1;
      while (!AES_DONE && lat < 30) begin
         tick();
         lat++;
      end
      check("b_ct", AES_MSG_ENC, CT_B);
      check("b_latency", 128'(lat), 128'd10);

      // Start-while-busy: new inputs and a START pulse five cycles in are ignored.
      AES_KEY    = KEY_C1;
      AES_MSG_PT = PT_C1;
      AES_START  = 1'b1;
      tick();
      AES_START  = 1'b0;
      lat = 0;
      while (!AES_DONE && lat < 30) begin
         if (lat == 4) begin
            AES_KEY    = {$urandom, $urandom, $urandom, $urandom};
            AES_MSG_PT = {$urandom, $urandom, $urandom, $urandom};
            AES_START  = 1'b1;
         end
         tick();
         AES_START = 1'b0;
         lat++;
         if (!AES_DONE) check($sformatf("busy_hold_%0d", lat), 128'(AES_BUSY), 128'd1);
      end
      check("busy_start_ct", AES_MSG_ENC, CT_C1);
      check("busy_start_latency", 128'(lat), 128'd10);

      // Back-to-back: START with App. B in the cycle DONE is seen.
      AES_KEY    = KEY_B;
      AES_MSG_PT = PT_B;
      AES_START  = 1'b1;
      tick();
      AES_START  = 1'b0;
      check("b2b_done_drop", 128'(AES_DONE), 128'd0);
      check("b2b_busy", 128'(AES_BUSY), 128'd1);
      lat = 0;
      while (!AES_DONE && lat < 30) begin
         check($sformatf("b2b_hold_%0d", lat), AES_MSG_ENC, CT_C1);
         tick();
         lat++;
      end
      check("b2b_ct", AES_MSG_ENC, CT_B);
      check("b2b_latency", 128'(lat), 128'd10);

      // Reset in the middle of an operation.
      AES_KEY    = KEY_C1;
      AES_MSG_PT = PT_C1;
      AES_START  = 1'b1;
      tick();
      AES_START  = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      RESET = 1'b1;
      tick();
      check("midrst_done", 128'(AES_DONE), 128'd0);
      check("midrst_busy", 128'(AES_BUSY), 128'd0);
      check("midrst_enc", AES_MSG_ENC, 128'd0);

      // RESET and START together: reset wins, nothing starts.
      AES_START = 1'b1;
      tick();
      check("rst_start_busy", 128'(AES_BUSY), 128'd0);
      RESET     = 1'b0;
      AES_START = 1'b0;
      tick();
      check("rst_start_idle", 128'(AES_BUSY), 128'd0);

      run_op(KEY_C1, PT_C1, ct, lat);
      check("post_rst_ct", ct, CT_C1);
      check("post_rst_latency", 128'(lat), 128'd10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
